// File: rtl/npc_ras_pkg.sv
// rtl/npc_ras_pkg.sv - shared next-PC operation encodings (ctrl_encode_def)
package npc_ras_pkg;

    typedef enum logic [2:0] {
        NPC_PLUS4  = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JALR   = 3'b100
    } npc_op_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with saturating occupancy
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   sp_q, sp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_idx;
    logic [PW-1:0]   top_idx;
    logic            wr_en;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(RAS_DEPTH));
    assign top_idx = sp_q - PW'(1);
    assign top     = empty ? '0 : mem_q[top_idx];

    // sp_q is the next free slot; wrapping it overwrites the oldest entry when full
    always_comb begin
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        wr_en  = push;
        wr_idx = sp_q;
        do_pop = pop && !empty;
        if (do_pop && push) begin
            wr_idx = top_idx;
        end else if (do_pop) begin
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end else if (push) begin
            sp_d = sp_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/npc_ras.sv
// rtl/npc_ras.sv - PC register, next-PC mux, RAS control and return counters
module npc_ras
    import npc_ras_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              RAS_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic [2:0]       NPCOp,
    input  logic [XLEN-1:0]  IMM,
    input  logic [XLEN-1:0]  aluout,
    input  logic             is_call,
    input  logic             is_ret,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  npc,
    output logic [XLEN-1:0]  ras_top,
    output logic             ras_empty,
    output logic             misalign,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  jalr_tgt;
    logic             advance;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_full_unused;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_tgt = aluout & ~XLEN'(1);
    assign advance  = !stall && !trap_valid;
    assign ras_push = advance && is_call;
    assign ras_pop  = advance && is_ret;

    always_comb begin
        npc = pc_plus4;
        if (trap_valid) begin
            npc = trap_vec;
        end else begin
            case (NPCOp)
                NPC_PLUS4:           npc = pc_plus4;
                NPC_BRANCH, NPC_JUMP: npc = pc_q + IMM;
                NPC_JALR:            npc = jalr_tgt;
                default:             npc = pc_plus4;
            endcase
        end
    end

    assign misalign = (npc[1:0] != 2'b00);

    always_comb begin
        pc_d          = stall ? pc_q : npc;
        ret_cnt_d     = ret_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ras_pop) begin
            if (ret_cnt_q != '1) begin
                ret_cnt_d = ret_cnt_q + CNT_W'(1);
            end
            // The prediction compared is the top seen before this cycle's pop
            if ((ras_empty || ras_top != jalr_tgt) && mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q          <= RESET_PC;
            ret_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ret_cnt_q     <= ret_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras_stack (
        .clk       (clk),
        .rstn      (rstn),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused)
    );

    assign pc          = pc_q;
    assign ret_cnt     = ret_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: doc/npc_ras.md
NPC_RAS -- requirements
Module: npc_ras

Interface
REQ-001 Parameter XLEN, default 32: PC/target width in bits.
REQ-002 Parameter RAS_DEPTH, default 8: return-address-stack entries; power of two, 2..64.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-004 Parameter CNT_W, default 32: width of the performance counters.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port rstn, input, 1: reset, synchronous and active-low.
REQ-007 Port stall, input, 1: hold PC and all state this cycle.
REQ-008 Port trap_valid, input, 1: redirect to trap_vec this cycle.
REQ-009 Port trap_vec, input, XLEN: trap target.
REQ-010 Port NPCOp, input, 3: next-PC operation; codes PLUS4=000, BRANCH=001, JUMP=010, JALR=100.
REQ-011 Port IMM, input, XLEN: branch/jump offset (sign-extended).
REQ-012 Port aluout, input, XLEN: JALR computed target.
REQ-013 Port is_call, input, 1: current instruction is a call (JAL/JALR writing x1/x5).
REQ-014 Port is_ret, input, 1: current instruction is a return (JALR via x1/x5, rd not link).
REQ-015 Port pc, output, XLEN: current PC register.
REQ-016 Port npc, output, XLEN: combinational next PC.
REQ-017 Port ras_top, output, XLEN: top-of-stack predicted return address; 0 when empty.
REQ-018 Port ras_empty, output, 1: stack holds zero valid entries.
REQ-019 Port misalign, output, 1: npc[1:0] != 0 (combinational).
REQ-020 Port ret_cnt and mispred_cnt, output, CNT_W each: returns seen, return mispredictions.

Function
REQ-021 npc SHALL be selected by priority: trap_valid -> trap_vec; else NPCOp: PLUS4 -> pc+4; BRANCH/JUMP -> pc+IMM; JALR -> {aluout[XLEN-1:1],1'b0}; undefined codes -> pc+4.
REQ-022 All additions SHALL be modulo 2^XLEN; wrap-around is silent, no flag.
REQ-023 On each rising edge with rstn=1 and stall=0, pc SHALL load npc; with stall=1, pc, RAS, pointers and counters SHALL hold.
REQ-024 misalign SHALL be asserted combinationally for the offending npc; pc SHALL still load it (trap raised elsewhere).
REQ-025 Call (is_call=1, not stalled, no trap) SHALL push pc+4 onto the RAS one cycle after the edge, i.e. visible on ras_top next cycle.
REQ-026 Return (is_ret=1, not stalled, no trap) SHALL pop the RAS at the edge.
REQ-027 is_call and is_ret together SHALL pop then push: top replaced by pc+4, occupancy unchanged.
REQ-028 Push when full SHALL overwrite the oldest entry (circular); occupancy saturates at RAS_DEPTH.
REQ-029 Pop when empty SHALL be a no-op; occupancy stays 0.
REQ-030 trap_valid=1 SHALL suppress RAS push/pop and counter updates that cycle.
REQ-031 ret_cnt SHALL increment on every accepted return; mispred_cnt SHALL increment when an accepted return finds the stack empty or ras_top != {aluout[XLEN-1:1],1'b0}.
REQ-032 Both counters SHALL saturate at all-ones.
REQ-033 npc for JALR SHALL always be aluout-derived; RAS is advisory, never alters npc.

Reset
REQ-034 On rising edge with rstn=0: pc=RESET_PC, RAS occupancy=0, pointers=0, ret_cnt=0, mispred_cnt=0; stall and all other inputs ignored.
REQ-035 Reset mid-operation SHALL discard all RAS contents; ras_empty=1 and ras_top=0 the cycle after.
REQ-036 RAS storage array need not be cleared; only validity (occupancy) is reset.

Structure
REQ-037 NPCOp codes SHALL come from the shared ctrl_encode_def definitions; no local literals.
REQ-038 RAS SHALL be a sub-module ras_stack (push, pop, push_data, top, empty, full; RAS_DEPTH, XLEN params); PC register, next-PC mux and counters stay in npc_ras.

Verification
REQ-039 Reset then 3 free cycles, NPCOp=PLUS4 -> pc = 0, 4, 8, 0xC.
REQ-040 pc=0x100, BRANCH IMM=0xFFFF_FFF0 -> pc=0xF0 next; JALR aluout=0x203 -> pc=0x202, misalign=1 during the JALR cycle.
REQ-041 Call at pc=0x40 then return with aluout=0x44 -> ras_top=0x44, ret_cnt=1, mispred_cnt=0, ras_empty=1 after.
REQ-042 RAS_DEPTH=8: 9 calls from pc=0x0,0x10..0x80 -> 9 returns; first 8 predict 0x84..0x14, 9th reports empty, mispred_cnt=1.
REQ-043 stall=1 for 2 cycles with is_call=1 -> pc, ras_top, counters unchanged; trap_valid with trap_vec=0x800 and is_ret=1 -> pc=0x800, no pop.
REQ-044 rstn=0 after 3 pushes -> next cycle pc=RESET_PC, ras_empty=1, counters 0.
